// File: rtl/pole_pkg.sv
// Shared lever types and constants for the pole/platform controller and sprite logic.
package pole_pkg;

    typedef enum logic [2:0] {
        POLE_RIGHT = 3'b001,
        POLE_MID   = 3'b010,
        POLE_LEFT  = 3'b100
    } pole_state_t;

    localparam logic [23:0] POLE_COLOR = 24'hceb244;

    // One lever step; pushes past an end leave the state unchanged.
    function automatic pole_state_t pole_step(input pole_state_t cur, input logic to_left);
        pole_state_t nxt;
        nxt = cur;
        unique case (cur)
            POLE_RIGHT: if (to_left)  nxt = POLE_MID;
            POLE_MID:   nxt = to_left ? POLE_LEFT : POLE_RIGHT;
            POLE_LEFT:  if (!to_left) nxt = POLE_MID;
            default:    nxt = POLE_RIGHT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/plat_mover.sv
// Yellow platform position register: steps plat_y toward the lever-selected target on each frame tick.
module plat_mover
    import pole_pkg::*;
#(
    parameter logic [9:0] PLAT_Y_UP   = 10'd300,
    parameter logic [9:0] PLAT_Y_DOWN = 10'd340,
    parameter int         STEP        = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  pole_state_t lever_now,
    input  pole_state_t lever_next,
    output logic [9:0]  plat_y,
    output logic        plat_moving
);

    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [9:0]  plat_y_q, plat_y_d;
    logic        plat_moving_q, plat_moving_d;
    logic [9:0]  tgt_now, tgt_next;
    logic [10:0] gap_up, gap_dn;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tgt_now  = (lever_now  == POLE_LEFT) ? PLAT_Y_DOWN : PLAT_Y_UP;
        tgt_next = (lever_next == POLE_LEFT) ? PLAT_Y_DOWN : PLAT_Y_UP;
        gap_up   = {1'b0, tgt_now} - {1'b0, plat_y_q};
        gap_dn   = {1'b0, plat_y_q} - {1'b0, tgt_now};
        plat_y_d = plat_y_q;
        if (frame_tick) begin
            if (tgt_now > plat_y_q)
                plat_y_d = (gap_up <= STEP_W) ? tgt_now : plat_y_q + STEP_W[9:0];
            else if (tgt_now < plat_y_q)
                plat_y_d = (gap_dn <= STEP_W) ? tgt_now : plat_y_q - STEP_W[9:0];
        end
        // Compared against the target the lever will hold after this edge, so the flag tracks the lever exactly.
        plat_moving_d = (plat_y_d != tgt_next);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            plat_y_q      <= PLAT_Y_UP;
            plat_moving_q <= 1'b0;
        end else begin
            plat_y_q      <= plat_y_d;
            plat_moving_q <= plat_moving_d;
        end
    end

    assign plat_y      = plat_y_q;
    assign plat_moving = plat_moving_q;

endmodule

// File: rtl/pole_lever_ctrl.sv
// Lever controller: round-robin arbitration of player pushes, RIGHT/MID/LEFT sequencing with frame cooldown.
module pole_lever_ctrl
    import pole_pkg::*;
#(
    parameter logic [9:0] PLAT_Y_UP       = 10'd300,
    parameter logic [9:0] PLAT_Y_DOWN     = 10'd340,
    parameter int         STEP            = 2,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fire_push_left,
    input  logic       fire_push_right,
    input  logic       water_push_left,
    input  logic       water_push_right,
    output logic [2:0] pole_status,
    output logic       board_yellow_down,
    output logic [9:0] plat_y,
    output logic       plat_moving,
    output logic       grant_fire,
    output logic       grant_water
);

    localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);

    pole_state_t   pole_q, pole_d;
    logic          byd_q, byd_d;
    logic          grant_fire_q, grant_fire_d;
    logic          grant_water_q, grant_water_d;
    logic          rr_water_q, rr_water_d;   // 1 when Watergirl holds priority
    logic [CW-1:0] cool_q, cool_d;

    logic fire_left, fire_right, water_left, water_right;
    logic fire_eff, water_eff, pick_water, step_left;

    always_comb begin
        fire_left   = fire_push_left  & ~fire_push_right;
        fire_right  = fire_push_right & ~fire_push_left;
        water_left  = water_push_left  & ~water_push_right;
        water_right = water_push_right & ~water_push_left;
        fire_eff    = (fire_left  && pole_q != POLE_LEFT) || (fire_right  && pole_q != POLE_RIGHT);
        water_eff   = (water_left && pole_q != POLE_LEFT) || (water_right && pole_q != POLE_RIGHT);
        pick_water  = water_eff && (!fire_eff || rr_water_q);
        step_left   = pick_water ? water_left : fire_left;

        pole_d        = pole_q;
        grant_fire_d  = 1'b0;
        grant_water_d = 1'b0;
        rr_water_d    = rr_water_q;
        cool_d        = cool_q;

        if (cool_q == '0) begin
            if (fire_eff || water_eff) begin
                pole_d        = pole_step(pole_q, step_left);
                grant_fire_d  = ~pick_water;
                grant_water_d = pick_water;
                cool_d        = COOL_LOAD;
                if (fire_eff && water_eff)
                    rr_water_d = ~rr_water_q;
            end
        end else if (frame_tick) begin
            cool_d = cool_q - 1'b1;
        end

        byd_d = (pole_d == POLE_LEFT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pole_q        <= POLE_RIGHT;
            byd_q         <= 1'b0;
            grant_fire_q  <= 1'b0;
            grant_water_q <= 1'b0;
            rr_water_q    <= 1'b0;
            cool_q        <= '0;
        end else begin
            pole_q        <= pole_d;
            byd_q         <= byd_d;
            grant_fire_q  <= grant_fire_d;
            grant_water_q <= grant_water_d;
            rr_water_q    <= rr_water_d;
            cool_q        <= cool_d;
        end
    end

    plat_mover #(
        .PLAT_Y_UP  (PLAT_Y_UP),
        .PLAT_Y_DOWN(PLAT_Y_DOWN),
        .STEP       (STEP)
    ) u_plat_mover (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .lever_now  (pole_q),
        .lever_next (pole_d),
        .plat_y     (plat_y),
        .plat_moving(plat_moving)
    );

    assign pole_status       = pole_q;
    assign board_yellow_down = byd_q;
    assign grant_fire        = grant_fire_q;
    assign grant_water       = grant_water_q;

endmodule
